// File: rtl/rf_xpr_t.sv
// 32x32 general-purpose register file: x0 reads zero, two registered read ports, write-through bypass, pending-write scoreboard.
// Reads take 1 cycle (Q after the edge) and BUSY is combinational; there is no backpressure, so decode gates RE and issue on BUSY.
module rf_xpr_t (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] rf_xpr_wrt0_D,
    input  logic [4:0]  rf_xpr_wrt0_WA,
    input  logic        rf_xpr_wrt0_WE,
    input  logic [4:0]  rf_xpr_rd0_RA,
    input  logic        rf_xpr_rd0_RE,
    output logic [31:0] rf_xpr_rd0_Q,
    output logic        rf_xpr_rd0_BUSY,
    input  logic [4:0]  rf_xpr_rd1_RA,
    input  logic        rf_xpr_rd1_RE,
    output logic [31:0] rf_xpr_rd1_Q,
    output logic        rf_xpr_rd1_BUSY,
    input  logic [4:0]  sb_set_WA,
    input  logic        sb_set_WE
);

    logic [31:0] regs [1:31];
    logic [31:1] pend;
    logic [31:1] pend_nxt;

    logic        wr_en;
    logic        set_en;
    logic        wr_hit0;
    logic        wr_hit1;
    logic [31:0] rd0_val;
    logic [31:0] rd1_val;

    assign wr_en   = rf_xpr_wrt0_WE && (rf_xpr_wrt0_WA != 5'd0);
    assign set_en  = sb_set_WE && (sb_set_WA != 5'd0);
    assign wr_hit0 = wr_en && (rf_xpr_wrt0_WA == rf_xpr_rd0_RA);
    assign wr_hit1 = wr_en && (rf_xpr_wrt0_WA == rf_xpr_rd1_RA);

    // A write-back this cycle forwards its data and releases the stall at once.
    always_comb begin
        rd0_val = 32'd0;
        if (rf_xpr_rd0_RA != 5'd0) begin
            rd0_val = wr_hit0 ? rf_xpr_wrt0_D : regs[rf_xpr_rd0_RA];
        end
    end

    always_comb begin
        rd1_val = 32'd0;
        if (rf_xpr_rd1_RA != 5'd0) begin
            rd1_val = wr_hit1 ? rf_xpr_wrt0_D : regs[rf_xpr_rd1_RA];
        end
    end

    assign rf_xpr_rd0_BUSY = (rf_xpr_rd0_RA != 5'd0) && pend[rf_xpr_rd0_RA] && !wr_hit0;
    assign rf_xpr_rd1_BUSY = (rf_xpr_rd1_RA != 5'd0) && pend[rf_xpr_rd1_RA] && !wr_hit1;

    // Set is applied after clear: a new producer issuing wins over the retiring one.
    always_comb begin
        pend_nxt = pend;
        if (wr_en) begin
            pend_nxt[rf_xpr_wrt0_WA] = 1'b0;
        end
        if (set_en) begin
            pend_nxt[sb_set_WA] = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (wr_en) begin
            regs[rf_xpr_wrt0_WA] <= rf_xpr_wrt0_D;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend         <= '0;
            rf_xpr_rd0_Q <= 32'd0;
            rf_xpr_rd1_Q <= 32'd0;
        end else begin
            pend <= pend_nxt;
            if (rf_xpr_rd0_RE) begin
                rf_xpr_rd0_Q <= rd0_val;
            end
            if (rf_xpr_rd1_RE) begin
                rf_xpr_rd1_Q <= rd1_val;
            end
        end
    end

endmodule

// File: tb/tb_rf_xpr_t.sv
// Bench for rf_xpr_t: vector table, async-reset sequence, then random traffic against a reference model.
module tb_rf_xpr_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] wrt0_d;
    logic [4:0]  wrt0_wa;
    logic        wrt0_we;
    logic [4:0]  rd0_ra;
    logic        rd0_re;
    logic [31:0] rd0_q;
    logic        rd0_busy;
    logic [4:0]  rd1_ra;
    logic        rd1_re;
    logic [31:0] rd1_q;
    logic        rd1_busy;
    logic [4:0]  set_wa;
    logic        set_we;

    int n_checks = 0;
    int n_fail   = 0;

    rf_xpr_t dut (
        .CLK             (CLK),
        .RST             (RST),
        .rf_xpr_wrt0_D   (wrt0_d),
        .rf_xpr_wrt0_WA  (wrt0_wa),
        .rf_xpr_wrt0_WE  (wrt0_we),
        .rf_xpr_rd0_RA   (rd0_ra),
        .rf_xpr_rd0_RE   (rd0_re),
        .rf_xpr_rd0_Q    (rd0_q),
        .rf_xpr_rd0_BUSY (rd0_busy),
        .rf_xpr_rd1_RA   (rd1_ra),
        .rf_xpr_rd1_RE   (rd1_re),
        .rf_xpr_rd1_Q    (rd1_q),
        .rf_xpr_rd1_BUSY (rd1_busy),
        .sb_set_WA       (set_wa),
        .sb_set_WE       (set_we)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] d;
        logic        re0;
        logic [4:0]  ra0;
        logic        re1;
        logic [4:0]  ra1;
        logic        sw;
        logic [4:0]  sa;
        logic        b0;
        logic        b1;
        logic [31:0] q0;
        logic [31:0] q1;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] d,
                                input logic re0, input logic [4:0] ra0,
                                input logic re1, input logic [4:0] ra1,
                                input logic sw, input logic [4:0] sa,
                                input logic b0, input logic b1,
                                input logic [31:0] q0, input logic [31:0] q1);
        vec_t v;
        v.we = we; v.wa = wa; v.d = d;
        v.re0 = re0; v.ra0 = ra0; v.re1 = re1; v.ra1 = ra1;
        v.sw = sw; v.sa = sa;
        v.b0 = b0; v.b1 = b1; v.q0 = q0; v.q1 = q1;
        return v;
    endfunction

    // Reference model
    logic [31:0] m_regs [32];
    logic [31:0] m_pend;
    logic [31:0] m_q0;
    logic [31:0] m_q1;
    logic [31:0] exp_q [$];

    function automatic logic [31:0] m_rd(input logic [4:0] ra, input vec_t v);
        if (ra == 5'd0) return 32'd0;
        if (v.we && v.wa == ra) return v.d;
        return m_regs[ra];
    endfunction

    function automatic logic m_busy(input logic [4:0] ra, input vec_t v);
        return (ra != 5'd0) && m_pend[ra] && !(v.we && v.wa == ra);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_pend = 32'd0;
        m_q0   = 32'd0;
        m_q1   = 32'd0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Starts at posedge+1; leaves at the next posedge+1.
    task automatic run_cycle(input vec_t v, input bit tbl, input string tag);
        logic [31:0] e0, e1, n0, n1;
        logic        eb0, eb1;
        wrt0_we = v.we; wrt0_wa = v.wa; wrt0_d = v.d;
        rd0_re  = v.re0; rd0_ra = v.ra0;
        rd1_re  = v.re1; rd1_ra = v.ra1;
        set_we  = v.sw; set_wa = v.sa;
        #3;
        eb0 = tbl ? v.b0 : m_busy(v.ra0, v);
        eb1 = tbl ? v.b1 : m_busy(v.ra1, v);
        chk($sformatf("%s busy0", tag), {31'd0, rd0_busy}, {31'd0, eb0});
        chk($sformatf("%s busy1", tag), {31'd0, rd1_busy}, {31'd0, eb1});
        n0 = v.re0 ? m_rd(v.ra0, v) : m_q0;
        n1 = v.re1 ? m_rd(v.ra1, v) : m_q1;
        e0 = tbl ? v.q0 : n0;
        e1 = tbl ? v.q1 : n1;
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        @(posedge CLK);
        m_q0 = n0;
        m_q1 = n1;
        if (v.we && v.wa != 5'd0) begin
            m_regs[v.wa] = v.d;
            m_pend[v.wa] = 1'b0;
        end
        if (v.sw && v.sa != 5'd0) m_pend[v.sa] = 1'b1;
        #1;
        chk($sformatf("%s q0", tag), rd0_q, exp_q.pop_front());
        chk($sformatf("%s q1", tag), rd1_q, exp_q.pop_front());
    endtask

    vec_t tbl [18];
    vec_t rv;

    initial begin
        //            we wa  d             re0 ra0 re1 ra1 sw sa  b0 b1 q0            q1
        tbl[0]  = mk(0, 0,  32'h0,        1,  5,  0,  0,  0, 0,  0, 0, 32'h0,        32'h0);
        tbl[1]  = mk(1, 7,  32'hDEADBEEF, 0,  0,  0,  0,  0, 0,  0, 0, 32'h0,        32'h0);
        tbl[2]  = mk(0, 0,  32'h0,        0,  0,  1,  7,  0, 0,  0, 0, 32'h0,        32'hDEADBEEF);
        tbl[3]  = mk(1, 0,  32'h12345678, 1,  0,  0,  0,  0, 0,  0, 0, 32'h0,        32'hDEADBEEF);
        tbl[4]  = mk(0, 0,  32'h0,        1,  0,  1,  0,  0, 0,  0, 0, 32'h0,        32'h0);
        tbl[5]  = mk(1, 3,  32'h11111111, 0,  0,  0,  0,  0, 0,  0, 0, 32'h0,        32'h0);
        tbl[6]  = mk(1, 3,  32'h22222222, 1,  3,  1,  3,  0, 0,  0, 0, 32'h22222222, 32'h22222222);
        tbl[7]  = mk(1, 3,  32'h33333333, 0,  3,  0,  3,  0, 0,  0, 0, 32'h22222222, 32'h22222222);
        tbl[8]  = mk(0, 0,  32'h0,        0,  9,  0,  0,  1, 9,  0, 0, 32'h22222222, 32'h22222222);
        tbl[9]  = mk(0, 0,  32'h0,        0,  9,  0,  9,  0, 0,  1, 1, 32'h22222222, 32'h22222222);
        tbl[10] = mk(1, 9,  32'hA5A5A5A5, 1,  9,  0,  9,  0, 0,  0, 0, 32'hA5A5A5A5, 32'h22222222);
        tbl[11] = mk(0, 0,  32'h0,        0,  9,  0,  0,  0, 0,  0, 0, 32'hA5A5A5A5, 32'h22222222);
        tbl[12] = mk(0, 0,  32'h0,        0,  0,  0,  4,  1, 4,  0, 0, 32'hA5A5A5A5, 32'h22222222);
        tbl[13] = mk(1, 4,  32'h0BADF00D, 0,  0,  0,  4,  1, 4,  0, 0, 32'hA5A5A5A5, 32'h22222222);
        tbl[14] = mk(0, 0,  32'h0,        0,  0,  1,  4,  0, 0,  0, 1, 32'hA5A5A5A5, 32'h0BADF00D);
        tbl[15] = mk(1, 4,  32'h44444444, 0,  12, 0,  4,  1, 12, 0, 0, 32'hA5A5A5A5, 32'h0BADF00D);
        tbl[16] = mk(0, 0,  32'h0,        0,  12, 1,  4,  1, 0,  1, 0, 32'hA5A5A5A5, 32'h44444444);
        tbl[17] = mk(0, 0,  32'h0,        0,  0,  1,  3,  0, 0,  0, 0, 32'hA5A5A5A5, 32'h33333333);

        RST = 1'b1;
        wrt0_we = 0; wrt0_wa = 0; wrt0_d = 0;
        rd0_re = 0; rd0_ra = 5'd5; rd1_re = 0; rd1_ra = 5'd7;
        set_we = 0; set_wa = 0;
        model_reset();
        #12;
        chk("reset q0", rd0_q, 32'h0);
        chk("reset q1", rd1_q, 32'h0);
        chk("reset busy0", {31'd0, rd0_busy}, 32'h0);
        chk("reset busy1", {31'd0, rd1_busy}, 32'h0);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 18; i++) begin
            run_cycle(tbl[i], 1'b1, $sformatf("vec%0d", i));
        end

        // Async reset between edges with live state
        run_cycle(mk(1, 10, 32'hCAFEF00D, 0, 0, 0, 0, 1, 10, 0, 0, 32'hA5A5A5A5, 32'h33333333), 1'b1, "ar_setup");
        run_cycle(mk(0, 0, 32'h0, 1, 10, 0, 12, 0, 0, 1, 1, 32'hCAFEF00D, 32'h33333333), 1'b1, "ar_read");
        #1 RST = 1'b1;
        #1;
        chk("ar q0", rd0_q, 32'h0);
        chk("ar q1", rd1_q, 32'h0);
        chk("ar busy0", {31'd0, rd0_busy}, 32'h0);
        chk("ar busy1", {31'd0, rd1_busy}, 32'h0);
        RST = 1'b0;
        model_reset();
        run_cycle(mk(0, 0, 32'h0, 1, 10, 1, 7, 0, 0, 0, 0, 32'h0, 32'h0), 1'b1, "ar_after");

        for (int i = 0; i < 300; i++) begin
            rv = mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                    1'b0, 1'b0, 32'h0, 32'h0);
            run_cycle(rv, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_xpr_t.md
# rf_xpr_t

General-purpose register file (32 × 32-bit, x0 hard-wired zero) that receives the write-back stage's `rf_xpr_wrt0_*` write port and serves two registered read ports to the decode/operand-fetch stage. It bypasses writes to reads in the same cycle. It also keeps a pending-write scoreboard, so decode can stall on an operand whose producer has issued but not yet written back.

## Interface
- Parameters: none. Widths are fixed: 32-bit data, 5-bit address, 32 entries.
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous and active-high.
- rf_xpr_wrt0_D  input  32  write data from write-back.
- rf_xpr_wrt0_WA  input  5  write address.
- rf_xpr_wrt0_WE  input  1  write enable.
- rf_xpr_rd0_RA  input  5  read port 0 address.
- rf_xpr_rd0_RE  input  1  read port 0 enable.
- rf_xpr_rd0_Q  output  32  read port 0 data, registered.
- rf_xpr_rd0_BUSY  output  1  read port 0 operand pending, combinational.
- rf_xpr_rd1_RA, rf_xpr_rd1_RE, rf_xpr_rd1_Q, rf_xpr_rd1_BUSY: same as port 0, for read port 1.
- sb_set_WA  input  5  destination register of the instruction issuing this cycle.
- sb_set_WE  input  1  mark sb_set_WA as pending.

## Operation
- **Storage:** regs[1..31] are 32-bit flops; regs[0] does not exist and always reads 0.
- **Write:**
  - If wrt0_WE=1 and WA≠0, then regs[WA] ← D at the edge.
  - A write with WA=0 is ignored: no storage change, no scoreboard change.
- **Read, per port p:**
  - If rdp_RE=1, then rdp_Q ← value at the edge:
    - value = 0 when RA=0;
    - else value = wrt0_D when wrt0_WE=1 and WA==RA (write-through bypass);
    - else value = regs[RA].
  - If rdp_RE=0, rdp_Q holds its previous value.
  - The two ports are fully independent. They may use the same address, and both see the bypass.
- **Scoreboard:** pend[31:1], one bit per register.
  - set = sb_set_WE && sb_set_WA≠0 sets pend[sb_set_WA].
  - clr = wrt0_WE && wrt0_WA≠0 clears pend[wrt0_WA].
  - When set and clr target the same address in the same cycle, set wins and the bit ends at 1: a new producer has issued and the old one is retiring.
  - Set and clr on different addresses both take effect.
- **BUSY, per port p (combinational):**
  - rdp_BUSY = (RA≠0) && pend[RA] && !(wrt0_WE && wrt0_WA==RA).
  - A write-back in the current cycle therefore unblocks the read in that same cycle, consistent with the bypass.
  - BUSY does not depend on RE.
  - sb_set in the current cycle does not affect BUSY until the next cycle.

## Timing
- **Reset (asynchronous, RST=1):**
  - regs[1..31]=0, pend=0, rd0_Q=0, rd1_Q=0.
  - BUSY=0 follows, since pend=0.
  - Reset takes effect immediately, mid-operation included. The write, read and set inputs of the edge coincident with RST are discarded.
- **Read latency:** 1 cycle, from RA/RE sampled at edge N to Q valid after edge N.
- **Write latency:**
  - Stored at edge N.
  - A read at edge N of the same address gets the new data via the bypass.
  - A read at edge N+1 gets it from storage.
- **Scoreboard latency:** set at edge N shows as BUSY from cycle N+1. Clear is visible combinationally in cycle N and stored at edge N.
- **No handshake:** the block never stalls. Decode gates its RE and issue on BUSY.
- **No wrap-around or overflow:** pend is a set/clear bit, not a counter. Multiple in-flight writes to the same register are not tracked; the first write-back clears the bit.

## Test plan
- **Reset then read:** assert RST, release, read x5 on port 0 with RE=1 -> rd0_Q=0x00000000 one cycle later; both BUSY=0.
- **Write then read, and x0 write:**
  - Write 0xDEADBEEF to x7 at edge N. Read x7 on port 1 at edge N+1 -> rd1_Q=0xDEADBEEF.
  - Write 0x12345678 to x0, then read x0 -> rd0_Q=0.
- **Same-cycle bypass:**
  - x3 holds 0x11111111. In one cycle, write 0x22222222 to x3 and read x3 on both ports -> both Q=0x22222222 after the edge.
  - In the next cycle, read again with RE=0 -> both Q hold 0x22222222.
- **Scoreboard set/clear:**
  - sb_set x9 at edge N; in cycle N+1, rd0_RA=9 -> rd0_BUSY=1.
  - In cycle M, write x9 with 0xA5A5A5A5 -> rd0_BUSY=0 combinationally in cycle M, and a read in M returns 0xA5A5A5A5.
  - After edge M, BUSY stays 0.
- **Set/clear collision:** pend[4]=1; in one cycle, sb_set x4 and write x4 -> after the edge, rd1_RA=4 gives rd1_BUSY=1 and regs[4] holds the written data.
- **Asynchronous reset mid-operation:** with x10 nonzero, pend[10]=1 and rd0_Q≠0, pulse RST between edges -> Q=0, BUSY=0 and regs[10]=0 immediately, without waiting for a clock edge.
